load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the ALU and the byte-addressed, big-endian 32-bit DataMemory of the MIPS core. It takes one load/store request at a time with a byte, half or word size and alignment, and drives DataMemory's address, write-data and read/write strobes. Sub-word stores are done as read-modify-write. Load data is extracted, extended and returned to the write-back path as a registered response.

## Interface
- ADDR_W, default 8: implemented byte-address bits (256-byte DataMemory).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address (ALUResult).
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  request rejected, no memory access made.
- mem_addr  out  32  word-aligned address to DataMemory.
- mem_wdata  out  32  word to write.
- mem_read  out  1  DataMemory read strobe.
- mem_write  out  1  DataMemory write strobe; the write happens at the next clk edge.
- mem_rdata  in  32  DataMemory combinational read data.

## Operation
- States:
  - IDLE: req_ready = 1.
  - READ: load read.
  - RMW: sub-word store read.
  - WRITE: store write.
  - RESP: response cycle.
- Acceptance: a request is taken on an edge where req_valid && req_ready. At that edge the unit registers the request fields and sets mem_addr = {req_addr[31:2], 2'b00}.
- Fault check at acceptance. A fault is raised if any of these holds:
  - req_size == 11;
  - half access with req_addr[0] != 0;
  - word access with req_addr[1:0] != 0;
  - req_addr[31:ADDR_W] != 0.
  - On a fault: go to RESP with resp_fault = 1; mem_read and mem_write are never asserted.
- Transitions:
  - Load: IDLE → READ → RESP.
  - Word store: IDLE → WRITE → RESP.
  - Byte/half store: IDLE → RMW → WRITE → RESP.
  - RESP → IDLE unconditionally.
- Lane mapping (big-endian): byte offset k occupies bits [31-8k : 24-8k]. A half at offset 0 is [31:16]; at offset 2 it is [15:0].
- Loads: the selected lane is taken from mem_rdata in READ, then zero- or sign-extended per req_signed. Word loads ignore req_signed.
- Stores: byte stores use req_wdata[7:0]; half stores use req_wdata[15:0]. The value is merged into the mem_rdata word captured in RMW. All other lanes keep the old value. The merged word is registered as mem_wdata for WRITE.
- Strobes: mem_read = 1 only in READ and RMW; mem_write = 1 only in WRITE. They are never asserted together.
- Reset values: state IDLE; resp_valid, resp_fault, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata = 0; req_ready = 1.

## Timing
- Accept edge = cycle 0.
- Latency to resp_valid:
  - Fault: 1 cycle.
  - Load and word store: 2 cycles.
  - Byte/half store: 3 cycles.
- resp_valid is high for exactly one cycle. There is no response back-pressure; the consumer must take it.
- req_ready is low from the accept edge until RESP ends. At most one request is in flight; there are no back-to-back accepts.
- mem_rdata is sampled at the end of READ/RMW. DataMemory reads are combinational within that cycle.
- Reset mid-operation: state, strobes and the response clear at once (asynchronous). A store interrupted before its WRITE edge leaves memory unchanged. No response is produced for an aborted request.
- req_valid held high with changing fields while req_ready = 0: those fields are ignored.

## Structure
- Package mips_lsu_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - ADDR_W default.
- Sub-module lsu_lane_align (combinational): extract/extend for loads and merge for stores, given offset, size, signed flag, old word and new data. It is reused by the core's forwarding logic.

## Test plan
- Memory word 0x10 = 0x8899AABB. lb signed @0x11 → resp_rdata 0xFFFFFF99, resp_valid 2 cycles after accept, mem_read high in exactly 1 cycle.
- lhu @0x12 on the same word → 0x0000AABB. lh @0x10 → 0xFFFF8899. lw @0x10 → 0x8899AABB.
- sb @0x13, wdata 0x123456CC → word 0x10 becomes 0x8899AACC. mem_read 1 cycle, then mem_write 1 cycle, resp_valid 3 cycles after accept.
- sw @0x10, wdata 0xDEADBEEF → word 0xDEADBEEF, no mem_read cycle, resp_valid at cycle 2.
- lw @0x12, sh @0x11, req_size 11 and lw @0x100 → each gives resp_fault = 1 at cycle 1; mem_read/mem_write never assert; memory unchanged.
- sh @0x10 with rst pulled low during RMW → strobes drop immediately, word 0x10 unchanged, req_ready = 1 after rst releases, next request accepted normally.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit.
// Size encodings, sequencer states and default address width.
package mips_lsu_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract/extend for loads and merge for stores.
// Purely combinational so the forwarding path can reuse it.
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] mask;

    // Offset k lives at bits [31-8k -: 8]; shift it down / new data up.
    always_comb begin
        sh_b      = {2'd3 - off, 3'b000};
        sh_h      = {2'd2 - off, 3'b000};
        byte_v    = 8'(old_word >> sh_b);
        half_v    = 16'(old_word >> sh_h);
        mask      = 32'h0;
        load_data = old_word;
        merged    = new_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sgn & byte_v[7]}}, byte_v};
                mask      = 32'h0000_00FF << sh_b;
                merged    = (old_word & ~mask)
                          | (32'(new_data[7:0]) << sh_b);
            end
            SZ_HALF: begin
                load_data = {{16{sgn & half_v[15]}}, half_v};
                mask      = 32'h0000_FFFF << sh_h;
                merged    = (old_word & ~mask)
                          | (32'(new_data[15:0]) << sh_h);
            end
            default: begin
                load_data = old_word;
                merged    = new_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the ALU and big-endian DataMemory.
// Sub-word stores are read-modify-write; responses are registered.
module load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [29:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        fault_now;
    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_lane_align u_align (
        .off       (off_q),
        .size      (size_q),
        .sgn       (sgn_q),
        .old_word  (mem_rdata),
        .new_data  (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Reject illegal size, misalignment and out-of-range addresses.
    always_comb begin
        fault_now = 1'b0;
        if (req_size == 2'b11)
            fault_now = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            fault_now = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            fault_now = 1'b1;
        if ((req_addr >> ADDR_W) != 32'h0)
            fault_now = 1'b1;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        wdata_d  = wdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    wdata_d = req_wdata;
                    maddr_d = req_addr[31:2];
                    rdata_d = 32'h0;
                    fault_d = fault_now;
                    if (fault_now)
                        state_d = ST_RESP;
                    else if (!req_write)
                        state_d = ST_READ;
                    else if (req_size == SZ_WORD) begin
                        mwdata_d = req_wdata;
                        state_d  = ST_WRITE;
                    end else
                        state_d = ST_RMW;
                end
            end
            ST_READ: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW: begin
                mwdata_d = merged;
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            off_q    <= 2'b00;
            size_q   <= SZ_BYTE;
            sgn_q    <= 1'b0;
            wdata_q  <= 32'h0;
            maddr_q  <= 30'h0;
            mwdata_q <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            wdata_q  <= wdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_fault = resp_valid & fault_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = {maddr_q, 2'b00};
    assign mem_wdata  = mwdata_q;
    assign mem_read   = (state_q == ST_READ) | (state_q == ST_RMW);
    assign mem_write  = (state_q == ST_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed test for load_store_unit against a word-array DataMemory.
// Each request checks data, fault, latency and strobe cycle counts.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:63];
    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[7:2]];

    always @(posedge clk)
        if (mem_write)
            dmem[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag,
                          input logic w,
                          input logic [1:0] sz,
                          input logic sg,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [31:0] exp_rd,
                          input logic exp_flt,
                          input int exp_lat,
                          input int exp_nr,
                          input int exp_nw);
        int cyc;
        int nr;
        int nw;
        int both;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_write = ~w;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h5555_5555;
        cyc  = 1;
        nr   = 0;
        nw   = 0;
        both = 0;
        while (!resp_valid && cyc < 8) begin
            if (mem_read) nr++;
            if (mem_write) nw++;
            if (mem_read && mem_write) both++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_fault"}, 32'(resp_fault), 32'(exp_flt));
        check({tag, "_nread"}, 32'(nr), 32'(exp_nr));
        check({tag, "_nwrite"}, 32'(nw), 32'(exp_nw));
        check({tag, "_both"}, 32'(both), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            dmem[i] = 32'h0101_0101 * i;
        dmem[4] = 32'h8899_AABB;

        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_rd", 32'(mem_read), 32'd0);
        check("rst_wr", 32'(mem_write), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_mwdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_req("lb", 0, 2'b00, 1, 32'h11, 0, 32'hFFFF_FF99, 0, 2, 1, 0);
        do_req("lbu", 0, 2'b00, 0, 32'h10, 0, 32'h0000_0088, 0, 2, 1, 0);
        do_req("lhu", 0, 2'b01, 0, 32'h12, 0, 32'h0000_AABB, 0, 2, 1, 0);
        do_req("lh", 0, 2'b01, 1, 32'h10, 0, 32'hFFFF_8899, 0, 2, 1, 0);
        do_req("lw", 0, 2'b10, 1, 32'h10, 0, 32'h8899_AABB, 0, 2, 1, 0);
        do_req("lw14", 0, 2'b10, 0, 32'h14, 0, 32'h0505_0505, 0, 2, 1, 0);

        do_req("sb", 1, 2'b00, 0, 32'h13, 32'h1234_56CC, 0, 0, 3, 1, 1);
        check("sb_mem", dmem[4], 32'h8899_AACC);
        do_req("sw", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 2, 0, 1);
        check("sw_mem", dmem[4], 32'hDEAD_BEEF);
        do_req("sh", 1, 2'b01, 0, 32'h10, 32'h7777_CAFE, 0, 0, 3, 1, 1);
        check("sh_mem", dmem[4], 32'hCAFE_BEEF);
        do_req("sb1", 1, 2'b00, 0, 32'h11, 32'h0000_0012, 0, 0, 3, 1, 1);
        check("sb1_mem", dmem[4], 32'hCA12_BEEF);

        do_req("f_lw12", 0, 2'b10, 0, 32'h12, 0, 0, 1, 1, 0, 0);
        do_req("f_sh11", 1, 2'b01, 0, 32'h11, 32'hFFFF, 0, 1, 1, 0, 0);
        do_req("f_sz3", 1, 2'b11, 0, 32'h10, 32'h1, 0, 1, 1, 0, 0);
        do_req("f_lw100", 0, 2'b10, 0, 32'h100, 0, 0, 1, 1, 0, 0);
        do_req("f_sw110", 1, 2'b10, 0, 32'h110, 32'h1, 0, 1, 1, 0, 0);
        check("f_mem", dmem[4], 32'hCA12_BEEF);

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b01;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ab_rmw_rd", 32'(mem_read), 32'd1);
        rst = 1'b0;
        #1;
        check("ab_rd", 32'(mem_read), 32'd0);
        check("ab_wr", 32'(mem_write), 32'd0);
        check("ab_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ab_ready", 32'(req_ready), 32'd1);
        check("ab_valid2", 32'(resp_valid), 32'd0);
        check("ab_mem", dmem[4], 32'hCA12_BEEF);
        do_req("ab_lw", 0, 2'b10, 0, 32'h10, 0, 32'hCA12_BEEF, 0, 2, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
